delta_tile_sequencer: RTL and testbench
=======================================

DELTA_TILE_SEQUENCER -- requirements
Module: delta_tile_sequencer

Interface
REQ-001 SHALL have parameter PU_NUM, default 4: number of processing units.
REQ-002 SHALL have parameter PU_OC, default 8: output channels per PU per tile.
REQ-003 SHALL have parameter TILE_IC, default 8: input channels per tile.
REQ-004 SHALL have parameters TILE_OH and TILE_OW, default 8 each: output rows and columns per tile.
REQ-005 SHALL have parameters CW (channel width) and FW (feature-size width), default 10 and 9.
REQ-006 SHALL have ports clock (input, 1, clock) and reset (input, 1, reset); reset is synchronous and active-high; clock is clock.
REQ-007 SHALL have ports start (in, 1), ack (out, 1), done (out, 1), busy (out, 1): job handshake.
REQ-008 SHALL have ports ic_num, oc_num (in, CW) and orc_size (in, FW): layer input-channel, output-channel and output-feature sizes.
REQ-009 SHALL have ports load_input and store_output (in, 1): optional whole-layer SRAM phases.
REQ-010 SHALL have phase start strobes out (1 each): in_sram_start, bias_start, in_buf_start, op_start, out_buf_start, out_sram_start.
REQ-011 SHALL have matching done inputs (1 each): in_sram_fin, bias_fin, in_buf_fin, out_buf_fin, out_sram_fin.
REQ-012 SHALL have ports pu_finished (in, PU_NUM) and finish_cycle (out, 1).
REQ-013 SHALL have port dram_sel (out, 2): 0 input, 1 output, 2 bias, 3 weight.
REQ-014 SHALL have tile-origin outputs i_ch, o_ch (out, CW) and o_r, o_c (out, FW).
REQ-015 SHALL have outputs pu_ic_num (out, CW) and pu_oc_num (out, PU_NUM*CW, PU k at bits [k*CW +: CW]).
REQ-016 SHALL have output perf_op_cycles (out, 32).

Function
REQ-017 SHALL implement FSM states IDLE, ACK, ISR_ST, ISR_WT, CHECK, BIAS_ST, BIAS_WT, IBUF_ST, IBUF_WT, OP_ST, OP_WT, OP_FIN, OBUF_ST, OBUF_WT, ADV, OSR_ST, OSR_WT, DONE.
REQ-018 SHALL transition IDLE->ACK on start; ACK is one cycle, ack=1, and latches ic_num/oc_num/orc_size/load_input/store_output; later input changes are ignored until DONE.
REQ-019 SHALL transition ACK->ISR_ST if load_input, else ACK->CHECK; ISR_ST pulses in_sram_start and then waits in ISR_WT until in_sram_fin, then goes to CHECK.
REQ-020 SHALL, in CHECK, go to OSR_ST (store_output=1) or DONE when all tiles are complete, else to BIAS_ST when i_ch==0, else to IBUF_ST.
REQ-021 SHALL pulse bias_start in BIAS_ST and wait for bias_fin, then go to IBUF_ST; IBUF_ST pulses in_buf_start and waits for in_buf_fin, then goes to OP_ST.
REQ-022 SHALL pulse op_start in OP_ST and clear a PU_NUM-bit sticky finish register.
REQ-023 SHALL, in OP_WT, OR pu_finished into the sticky register and go to OP_FIN once every PU whose pu_oc_num==0 or whose sticky bit is set.
REQ-024 SHALL assert finish_cycle for one cycle in OP_FIN, then go to OBUF_ST when the current input tile is the last one (i_ch+TILE_IC>=ic), else to ADV.
REQ-025 SHALL pulse out_buf_start in OBUF_ST, wait for out_buf_fin, then go to ADV; ADV advances the indices and returns to CHECK.
REQ-026 SHALL advance indices in the order i_ch (innermost, +TILE_IC), then o_c (+TILE_OW), o_r (+TILE_OH), o_ch (+PU_NUM*PU_OC, outermost), each wrapping to 0 when it reaches or exceeds its size.
REQ-027 SHALL mark all tiles complete when o_ch>=oc; partial tiles are processed, never truncated.
REQ-028 SHALL compute pu_ic_num = min(TILE_IC, ic-i_ch).
REQ-029 SHALL compute pu_oc_num[k] = clamp(oc-o_ch-k*PU_OC, 0, PU_OC), using signed or widened arithmetic so it never underflows.
REQ-030 SHALL pulse out_sram_start in OSR_ST and wait in OSR_WT for out_sram_fin, then go to DONE.
REQ-031 SHALL assert done for one cycle in DONE, then return to IDLE.
REQ-032 SHALL, when ic, oc or orc_size is 0 at ACK, go from CHECK directly to OSR_ST or DONE without issuing any tile strobe.
REQ-033 SHALL drive dram_sel: 0 in ISR_*/IBUF_*; 2 in BIAS_*; 3 in OP_*; 1 in OBUF_*/OSR_*; 0 elsewhere.
REQ-034 SHALL drive busy=1 in every state except IDLE.
REQ-035 SHALL ignore start outside IDLE; a fin input asserted in the same cycle as its *_ST strobe is not accepted.

Reset
REQ-036 SHALL, on reset, force state IDLE and clear all indices, latched configuration, the sticky register and perf_op_cycles; every strobe, ack, done, busy and finish_cycle output SHALL be 0 and dram_sel SHALL be 0.
REQ-037 SHALL let reset asserted mid-job abort that job immediately; no further strobes SHALL be issued.

Configuration
REQ-038 SHALL, with DELTA_SEQ_PERF_EN defined, clear perf_op_cycles at ACK and increment it by 1 (saturating) each cycle in OP_WT.
REQ-039 SHALL, without DELTA_SEQ_PERF_EN defined, tie perf_op_cycles to 0 and include no counter logic.

Verification
REQ-040 SHALL cover ic=16, oc=32, orc=8, defaults: 2 op_start pulses, 1 bias_start, 1 out_buf_start, done.
REQ-041 SHALL cover ic=12, oc=20, orc=10: pu_ic_num is 8 then 4, pu_oc_num is {8,8,4,0}, PU3 is masked, and 8 op_start pulses occur.
REQ-042 SHALL cover oc=0 with store_output=1: the sequence goes ACK->CHECK->OSR_ST->DONE with no bias, input-buffer or op strobes.
REQ-043 SHALL cover PUs finishing in different cycles (pulses on bits 0,1,2,3 at cycles 3,5,9,4): OP_FIN is entered only after cycle 9.
REQ-044 SHALL cover reset asserted in OP_WT: the next cycle shows IDLE with all outputs 0; a fresh start runs the job to completion.
REQ-045 SHALL cover DELTA_SEQ_PERF_EN defined with the PUs finishing 6 cycles after op_start on one tile: perf_op_cycles==6.

Source files
------------

// File: rtl/delta_tile_sequencer.sv
// delta_tile_sequencer: job-level sequencer for a tiled convolution layer.
// Walks the layer in tiles (i_ch innermost, then o_c, o_r, o_ch outermost),
// issuing SRAM/bias/buffer/op phase strobes and waiting on their fin inputs.
// Optional build macro: DELTA_SEQ_PERF_EN enables the perf_op_cycles counter
// (cycles spent in OP_WT for the current job); without it the output is 0.
//
// state   | meaning
// IDLE    | waiting for start
// ACK     | one-cycle acknowledge, configuration latched
// ISR_ST  | pulse in_sram_start (whole-layer input load)
// ISR_WT  | wait for in_sram_fin
// CHECK   | decide: finish, bias load, or input-buffer load
// BIAS_ST | pulse bias_start
// BIAS_WT | wait for bias_fin
// IBUF_ST | pulse in_buf_start
// IBUF_WT | wait for in_buf_fin
// OP_ST   | pulse op_start, clear PU finish flags
// OP_WT   | collect pu_finished until every active PU reported
// OP_FIN  | one-cycle finish_cycle
// OBUF_ST | pulse out_buf_start (last input tile only)
// OBUF_WT | wait for out_buf_fin
// ADV     | advance tile indices
// OSR_ST  | pulse out_sram_start (whole-layer output store)
// OSR_WT  | wait for out_sram_fin
// DONE    | one-cycle done
module delta_tile_sequencer #(
  parameter int PU_NUM  = 4,
  parameter int PU_OC   = 8,
  parameter int TILE_IC = 8,
  parameter int TILE_OH = 8,
  parameter int TILE_OW = 8,
  parameter int CW      = 10,
  parameter int FW      = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 ack,
  output logic                 done,
  output logic                 busy,
  input  logic [CW-1:0]        ic_num,
  input  logic [CW-1:0]        oc_num,
  input  logic [FW-1:0]        orc_size,
  input  logic                 load_input,
  input  logic                 store_output,
  output logic                 in_sram_start,
  output logic                 bias_start,
  output logic                 in_buf_start,
  output logic                 op_start,
  output logic                 out_buf_start,
  output logic                 out_sram_start,
  input  logic                 in_sram_fin,
  input  logic                 bias_fin,
  input  logic                 in_buf_fin,
  input  logic                 out_buf_fin,
  input  logic                 out_sram_fin,
  input  logic [PU_NUM-1:0]    pu_finished,
  output logic                 finish_cycle,
  output logic [1:0]           dram_sel,
  output logic [CW-1:0]        i_ch,
  output logic [CW-1:0]        o_ch,
  output logic [FW-1:0]        o_r,
  output logic [FW-1:0]        o_c,
  output logic [CW-1:0]        pu_ic_num,
  output logic [PU_NUM*CW-1:0] pu_oc_num,
  output logic [31:0]          perf_op_cycles
);

  typedef enum logic [4:0] {
    IDLE, ACK, ISR_ST, ISR_WT, CHECK, BIAS_ST, BIAS_WT, IBUF_ST, IBUF_WT,
    OP_ST, OP_WT, OP_FIN, OBUF_ST, OBUF_WT, ADV, OSR_ST, OSR_WT, DONE
  } state_t;

  // Steps are one bit wider than the indices so index+step never wraps.
  localparam logic [CW:0] IC_STEP = (CW+1)'(TILE_IC);
  localparam logic [CW:0] OC_STEP = (CW+1)'(PU_NUM*PU_OC);
  localparam logic [FW:0] OH_STEP = (FW+1)'(TILE_OH);
  localparam logic [FW:0] OW_STEP = (FW+1)'(TILE_OW);

  state_t              state, state_nxt;
  logic [CW-1:0]       ic_l, oc_l;
  logic [FW-1:0]       orc_l;
  logic                store_l;
  logic                all_done;
  logic [PU_NUM-1:0]   sticky;
  logic [PU_NUM-1:0]   pu_idle;

  logic [CW:0]         i_ch_nx, o_ch_nx, ic_rem;
  logic [FW:0]         o_c_nx, o_r_nx;
  logic                last_ic, wrap_c, wrap_r, wrap_oc, tiles_done, pus_done;

  assign i_ch_nx = {1'b0, i_ch} + IC_STEP;
  assign o_ch_nx = {1'b0, o_ch} + OC_STEP;
  assign o_c_nx  = {1'b0, o_c} + OW_STEP;
  assign o_r_nx  = {1'b0, o_r} + OH_STEP;
  assign last_ic = (i_ch_nx >= {1'b0, ic_l});
  assign wrap_c  = (o_c_nx >= {1'b0, orc_l});
  assign wrap_r  = (o_r_nx >= {1'b0, orc_l});
  assign wrap_oc = (o_ch_nx >= {1'b0, oc_l});

  // Any empty dimension means there is no tile to run at all.
  assign tiles_done = all_done || (ic_l == '0) || (oc_l == '0) || (orc_l == '0);

  // Input channels left in this tile, capped at the tile depth.
  assign ic_rem    = {1'b0, ic_l} - {1'b0, i_ch};
  assign pu_ic_num = ({1'b0, i_ch} >= {1'b0, ic_l}) ? '0 :
                     (ic_rem >= IC_STEP) ? CW'(TILE_IC) : ic_rem[CW-1:0];

  // Per-PU output channel count; compared before subtracting so it never underflows.
  for (genvar k = 0; k < PU_NUM; k++) begin : g_pu
    logic [CW+1:0] base, diff;
    assign base = {2'b00, o_ch} + (CW+2)'(k*PU_OC);
    assign diff = {2'b00, oc_l} - base;
    assign pu_idle[k] = ({2'b00, oc_l} <= base);
    assign pu_oc_num[k*CW +: CW] = pu_idle[k] ? '0 :
                                   (diff >= (CW+2)'(PU_OC)) ? CW'(PU_OC) : diff[CW-1:0];
  end

  // A PU counts as finished if it has no work this tile or has reported.
  assign pus_done = &(sticky | pu_finished | pu_idle);

  function automatic logic [1:0] sel_for(input state_t s);
    case (s)
      BIAS_ST, BIAS_WT:              sel_for = 2'd2;
      OP_ST, OP_WT, OP_FIN:          sel_for = 2'd3;
      OBUF_ST, OBUF_WT,
      OSR_ST, OSR_WT:                sel_for = 2'd1;
      default:                       sel_for = 2'd0;
    endcase
  endfunction

  // Next-state decision; fins are only looked at in the *_WT states.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACK;
      // load_input is sampled live here, the same instant it is latched.
      ACK:     state_nxt = load_input ? ISR_ST : CHECK;
      ISR_ST:  state_nxt = ISR_WT;
      ISR_WT:  if (in_sram_fin) state_nxt = CHECK;
      CHECK: begin
        if (tiles_done)       state_nxt = store_l ? OSR_ST : DONE;
        else if (i_ch == '0)  state_nxt = BIAS_ST;
        else                  state_nxt = IBUF_ST;
      end
      BIAS_ST: state_nxt = BIAS_WT;
      BIAS_WT: if (bias_fin) state_nxt = IBUF_ST;
      IBUF_ST: state_nxt = IBUF_WT;
      IBUF_WT: if (in_buf_fin) state_nxt = OP_ST;
      OP_ST:   state_nxt = OP_WT;
      OP_WT:   if (pus_done) state_nxt = OP_FIN;
      OP_FIN:  state_nxt = last_ic ? OBUF_ST : ADV;
      OBUF_ST: state_nxt = OBUF_WT;
      OBUF_WT: if (out_buf_fin) state_nxt = ADV;
      ADV:     state_nxt = CHECK;
      OSR_ST:  state_nxt = OSR_WT;
      OSR_WT:  if (out_sram_fin) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered outputs (decoded from the next state) and job datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      ack            <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
      in_sram_start  <= 1'b0;
      bias_start     <= 1'b0;
      in_buf_start   <= 1'b0;
      op_start       <= 1'b0;
      out_buf_start  <= 1'b0;
      out_sram_start <= 1'b0;
      finish_cycle   <= 1'b0;
      dram_sel       <= 2'd0;
      ic_l           <= '0;
      oc_l           <= '0;
      orc_l          <= '0;
      store_l        <= 1'b0;
      all_done       <= 1'b0;
      sticky         <= '0;
      i_ch           <= '0;
      o_ch           <= '0;
      o_r            <= '0;
      o_c            <= '0;
    end else begin
      state          <= state_nxt;
      ack            <= (state_nxt == ACK);
      done           <= (state_nxt == DONE);
      busy           <= (state_nxt != IDLE);
      in_sram_start  <= (state_nxt == ISR_ST);
      bias_start     <= (state_nxt == BIAS_ST);
      in_buf_start   <= (state_nxt == IBUF_ST);
      op_start       <= (state_nxt == OP_ST);
      out_buf_start  <= (state_nxt == OBUF_ST);
      out_sram_start <= (state_nxt == OSR_ST);
      finish_cycle   <= (state_nxt == OP_FIN);
      dram_sel       <= sel_for(state_nxt);
      case (state)
        ACK: begin
          ic_l     <= ic_num;
          oc_l     <= oc_num;
          orc_l    <= orc_size;
          store_l  <= store_output;
          all_done <= 1'b0;
          i_ch     <= '0;
          o_ch     <= '0;
          o_r      <= '0;
          o_c      <= '0;
        end
        OP_ST: sticky <= '0;
        OP_WT: sticky <= sticky | pu_finished;
        ADV: begin
          if (!last_ic) begin
            i_ch <= i_ch_nx[CW-1:0];
          end else begin
            i_ch <= '0;
            if (!wrap_c) begin
              o_c <= o_c_nx[FW-1:0];
            end else begin
              o_c <= '0;
              if (!wrap_r) begin
                o_r <= o_r_nx[FW-1:0];
              end else begin
                o_r <= '0;
                if (!wrap_oc) begin
                  o_ch <= o_ch_nx[CW-1:0];
                end else begin
                  o_ch     <= '0;
                  all_done <= 1'b1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DELTA_SEQ_PERF_EN
  // Saturating count of cycles spent waiting on the PUs during this job.
  always_ff @(posedge clock) begin
    if (reset || state == ACK)
      perf_op_cycles <= '0;
    else if (state == OP_WT && perf_op_cycles != '1)
      perf_op_cycles <= perf_op_cycles + 32'd1;
  end
`else
  assign perf_op_cycles = '0;
`endif

endmodule

// File: tb/tb_delta_tile_sequencer.sv
// tb_delta_tile_sequencer: table-driven and randomized jobs against a
// tile-list model, plus hand sequences for PU skew, early fins and reset abort.
module tb_delta_tile_sequencer;
  localparam int PU_NUM = 4, PU_OC = 8, TILE_IC = 8, TILE_OH = 8, TILE_OW = 8;
  localparam int CW = 10, FW = 9;

  logic clock = 1'b0;
  logic reset, start, ack, done, busy;
  logic [CW-1:0] ic_num, oc_num;
  logic [FW-1:0] orc_size;
  logic load_input, store_output;
  logic in_sram_start, bias_start, in_buf_start, op_start, out_buf_start, out_sram_start;
  logic in_sram_fin, bias_fin, in_buf_fin, out_buf_fin, out_sram_fin;
  logic [PU_NUM-1:0] pu_finished;
  logic finish_cycle;
  logic [1:0] dram_sel;
  logic [CW-1:0] i_ch, o_ch, pu_ic_num;
  logic [FW-1:0] o_r, o_c;
  logic [PU_NUM*CW-1:0] pu_oc_num;
  logic [31:0] perf_op_cycles;

  always #5 clock = ~clock;

  delta_tile_sequencer #(.PU_NUM(PU_NUM), .PU_OC(PU_OC), .TILE_IC(TILE_IC),
    .TILE_OH(TILE_OH), .TILE_OW(TILE_OW), .CW(CW), .FW(FW)) dut (
    .clock(clock), .reset(reset), .start(start), .ack(ack), .done(done), .busy(busy),
    .ic_num(ic_num), .oc_num(oc_num), .orc_size(orc_size),
    .load_input(load_input), .store_output(store_output),
    .in_sram_start(in_sram_start), .bias_start(bias_start), .in_buf_start(in_buf_start),
    .op_start(op_start), .out_buf_start(out_buf_start), .out_sram_start(out_sram_start),
    .in_sram_fin(in_sram_fin), .bias_fin(bias_fin), .in_buf_fin(in_buf_fin),
    .out_buf_fin(out_buf_fin), .out_sram_fin(out_sram_fin),
    .pu_finished(pu_finished), .finish_cycle(finish_cycle), .dram_sel(dram_sel),
    .i_ch(i_ch), .o_ch(o_ch), .o_r(o_r), .o_c(o_c),
    .pu_ic_num(pu_ic_num), .pu_oc_num(pu_oc_num), .perf_op_cycles(perf_op_cycles));

  int n_cmp = 0, n_fail = 0;

  typedef struct { int i, o, r, c, pic; logic [PU_NUM*CW-1:0] poc; } tile_t;
  typedef struct { int ops, bias, ibuf, obuf, isr, osr, acks, dones, fins;
                   int ack_lat, lat_fin, lat_b2i, osr_at; logic [31:0] perf; } res_t;
  typedef struct { int ic, oc, orc; bit ld, st; int ops, bias, obuf, isr, osr; } vec_t;

  tile_t exp_q[$];
  int m_ops, m_bias, m_obuf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp_v);
    end
  endtask

  // Expected tile walk: plain nested loops over the layer.
  task automatic build_model(input int ic, input int oc, input int orc);
    tile_t t;
    int v;
    exp_q.delete();
    m_ops = 0; m_bias = 0; m_obuf = 0;
    for (int o = 0; o < oc; o += PU_NUM*PU_OC)
      for (int r = 0; r < orc; r += TILE_OH)
        for (int c = 0; c < orc; c += TILE_OW)
          for (int i = 0; i < ic; i += TILE_IC) begin
            t.i = i; t.o = o; t.r = r; t.c = c;
            t.pic = (ic - i < TILE_IC) ? ic - i : TILE_IC;
            t.poc = '0;
            for (int k = 0; k < PU_NUM; k++) begin
              v = oc - o - k*PU_OC;
              if (v < 0) v = 0;
              if (v > PU_OC) v = PU_OC;
              t.poc[k*CW +: CW] = CW'(v);
            end
            exp_q.push_back(t);
            m_ops++;
            if (i == 0) m_bias++;
            if (i + TILE_IC >= ic) m_obuf++;
          end
  endtask

  function automatic logic [1:0] sel_of(input int p);
    case (p)
      1:       return 2'd2;
      3, 4:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  task automatic check_quiet(input string name);
    chk({name, "_ctl"}, {ack, done, busy, in_sram_start, bias_start, in_buf_start,
                         op_start, out_buf_start, out_sram_start, finish_cycle, dram_sel}, 0);
    chk({name, "_idx"}, {i_ch, o_ch, o_r, o_c}, 0);
    chk({name, "_pu_ic"}, pu_ic_num, 0);
    chk({name, "_pu_oc"}, pu_oc_num, 0);
    chk({name, "_perf"}, perf_op_cycles, 0);
  endtask

  // Drives one job and acts as the phase/PU responder, cycle by cycle at negedge.
  task automatic run_job(input int ic, input int oc, input int orc, input bit ld, input bit st,
                         input int fix_dly, input bit early, input bit pu_fixed,
                         input int s0, input int s1, input int s2, input int s3,
                         input bit abort, output res_t r);
    int cnt[5];
    int pcnt[PU_NUM];
    int sched[PU_NUM];
    int cyc, op_cyc, b_cyc;
    bit done_seen, finished;
    logic [4:0] strb, f;
    logic [PU_NUM-1:0] pf;
    tile_t t;
    sched = '{s0, s1, s2, s3};
    r = '{default: 0};
    build_model(ic, oc, orc);
    foreach (cnt[p]) cnt[p] = 0;
    foreach (pcnt[k]) pcnt[k] = 0;
    cyc = 0; op_cyc = -1; b_cyc = -1; done_seen = 0; finished = 0;
    @(negedge clock);
    start = 1; ic_num = CW'(ic); oc_num = CW'(oc); orc_size = FW'(orc);
    load_input = ld; store_output = st;
    while (!finished && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      f = '0; pf = '0;
      for (int p = 0; p < 5; p++)
        if (cnt[p] > 0) begin cnt[p]--; if (cnt[p] == 0) f[p] = 1'b1; end
      for (int k = 0; k < PU_NUM; k++)
        if (pcnt[k] > 0) begin pcnt[k]--; if (pcnt[k] == 0) pf[k] = 1'b1; end
      if (done_seen) begin
        chk("busy_after_done", busy, 0);
        finished = 1;
      end
      if (r.acks > 0 && cyc > r.ack_lat && !done_seen && !reset) begin
        ic_num = CW'($urandom); oc_num = CW'($urandom); orc_size = FW'($urandom);
        load_input = 1'($urandom); store_output = 1'($urandom); start = 1'($urandom);
      end
      strb = {out_sram_start, out_buf_start, in_buf_start, bias_start, in_sram_start};
      for (int p = 0; p < 5; p++) begin
        if (strb[p]) begin
          case (p)
            0: r.isr++;
            1: begin r.bias++; b_cyc = cyc; end
            2: begin r.ibuf++; if (b_cyc >= 0) r.lat_b2i = cyc - b_cyc; end
            3: r.obuf++;
            default: begin r.osr++; if (r.osr_at == 0) r.osr_at = cyc; end
          endcase
          chk($sformatf("dram_sel_phase%0d", p), dram_sel, sel_of(p));
          cnt[p] = (fix_dly > 0) ? fix_dly : int'($urandom_range(1, 3));
          if (early) f[p] = 1'b1;
        end
      end
      if (op_start) begin
        r.ops++; op_cyc = cyc;
        chk("dram_sel_op", dram_sel, 3);
        if (exp_q.size() == 0) chk("unexpected_op", 1, 0);
        else begin
          t = exp_q.pop_front();
          chk("i_ch", i_ch, t.i);
          chk("o_ch", o_ch, t.o);
          chk("o_r", o_r, t.r);
          chk("o_c", o_c, t.c);
          chk("pu_ic_num", pu_ic_num, t.pic);
          chk("pu_oc_num", pu_oc_num, t.poc);
          for (int k = 0; k < PU_NUM; k++)
            pcnt[k] = (t.poc[k*CW +: CW] != 0) ?
                      (pu_fixed ? sched[k] : int'($urandom_range(1, 4))) : 0;
        end
      end
      if (finish_cycle) begin
        r.fins++;
        if (op_cyc >= 0) r.lat_fin = cyc - op_cyc;
      end
      if (ack) begin r.acks++; r.ack_lat = cyc; end
      if (done) begin
        r.dones++; r.perf = perf_op_cycles; done_seen = 1; start = 0;
        chk("done_busy_sel", {busy, dram_sel}, 3'b100);
      end
      if (abort && op_cyc >= 0) begin
        if (cyc == op_cyc + 1) begin reset = 1; start = 0; end
        else if (cyc == op_cyc + 2) begin
          check_quiet("abort");
          reset = 0; finished = 1;
        end
      end
      {out_sram_fin, out_buf_fin, in_buf_fin, bias_fin, in_sram_fin} = f;
      pu_finished = pf;
    end
    if (!finished) chk("job_timeout", cyc, 0);
    if (!abort) begin
      chk("acks", r.acks, 1);
      chk("ack_lat", r.ack_lat, 1);
      chk("dones", r.dones, 1);
      chk("fins", r.fins, m_ops);
      chk("ibufs", r.ibuf, m_ops);
      chk("model_left", exp_q.size(), 0);
    end
    start = 0;
    {out_sram_fin, out_buf_fin, in_buf_fin, bias_fin, in_sram_fin} = '0;
    pu_finished = '0;
  endtask

  vec_t vecs[7];
  res_t r;
  int ric, roc, rorc;
  bit rld, rst_o;
  logic [31:0] perf_exp;

  initial begin
    vecs[0] = '{16, 32, 8,  0, 0, 2, 1, 1, 0, 0};
    vecs[1] = '{12, 20, 10, 1, 1, 8, 4, 4, 1, 1};
    vecs[2] = '{12, 0,  8,  0, 1, 0, 0, 0, 0, 1};
    vecs[3] = '{0,  16, 8,  1, 0, 0, 0, 0, 1, 0};
    vecs[4] = '{8,  40, 8,  0, 1, 2, 2, 2, 0, 1};
    vecs[5] = '{8,  8,  0,  0, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{9,  8,  9,  0, 0, 8, 4, 4, 0, 0};

    reset = 1; start = 0; ic_num = '0; oc_num = '0; orc_size = '0;
    load_input = 0; store_output = 0; pu_finished = '0;
    {out_sram_fin, out_buf_fin, in_buf_fin, bias_fin, in_sram_fin} = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_quiet("reset");
    reset = 0;

    for (int n = 0; n < 7; n++) begin
      run_job(vecs[n].ic, vecs[n].oc, vecs[n].orc, vecs[n].ld, vecs[n].st,
              0, 0, 0, 0, 0, 0, 0, 0, r);
      chk($sformatf("v%0d_ops", n), r.ops, vecs[n].ops);
      chk($sformatf("v%0d_bias", n), r.bias, vecs[n].bias);
      chk($sformatf("v%0d_obuf", n), r.obuf, vecs[n].obuf);
      chk($sformatf("v%0d_isr", n), r.isr, vecs[n].isr);
      chk($sformatf("v%0d_osr", n), r.osr, vecs[n].osr);
      if (n == 2) chk("oc0_osr_cycle", r.osr_at, 3);
    end

    // PUs report at different cycles; fins also pulsed alongside their strobes.
    run_job(8, 32, 8, 1, 1, 3, 1, 1, 3, 5, 9, 4, 0, r);
    chk("skew_ops", r.ops, 1);
    chk("skew_op_to_fin", r.lat_fin, 10);
    chk("early_bias_to_ibuf", r.lat_b2i, 4);
    chk("early_isr_osr", {r.isr[3:0], r.osr[3:0]}, 8'h11);

    // All active PUs finish 6 cycles after op_start.
`ifdef DELTA_SEQ_PERF_EN
    perf_exp = 32'd6;
`else
    perf_exp = 32'd0;
`endif
    run_job(8, 8, 8, 0, 0, 0, 0, 1, 6, 6, 6, 6, 0, r);
    chk("perf_op_cycles", r.perf, perf_exp);
    chk("perf_op_to_fin", r.lat_fin, 7);

    // Reset while waiting on the PUs, then a fresh job.
    run_job(8, 32, 8, 0, 1, 0, 0, 1, 20, 20, 20, 20, 1, r);
    chk("abort_ops", r.ops, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check_quiet($sformatf("post_abort%0d", c));
    end
    run_job(8, 8, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, r);
    chk("rerun_ops", r.ops, 1);
    chk("rerun_osr", r.osr, 1);

    for (int n = 0; n < 10; n++) begin
      ric = $urandom_range(0, 24); roc = $urandom_range(0, 66); rorc = $urandom_range(0, 17);
      rld = 1'($urandom); rst_o = 1'($urandom);
      run_job(ric, roc, rorc, rld, rst_o, 0, 0, 0, 0, 0, 0, 0, 0, r);
      chk($sformatf("rnd%0d_ops", n), r.ops, m_ops);
      chk($sformatf("rnd%0d_bias", n), r.bias, m_bias);
      chk($sformatf("rnd%0d_obuf", n), r.obuf, m_obuf);
      chk($sformatf("rnd%0d_isr_osr", n), {r.isr[3:0], r.osr[3:0]}, {3'b000, rld, 3'b000, rst_o});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
